ldl_rr_arbiter: RTL and testbench
=================================

LDL_RR_ARBITER -- requirements
Module: LDL_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 2, sets the grant index width; the requester count is N = 1<<WIDTH.
REQ-002 Parameter HOLD, default 8: the maximum number of cycles a grant is held; 0 disables the limit; legal range 0..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  request vector; bit i is requester i, level-sensitive.
REQ-006 done  input  1  current owner releases the grant; ignored unless gnt_vld=1.
REQ-007 gnt_vld  output  1  a grant is active, registered.
REQ-008 gnt_idx  output  WIDTH  binary index of the owner, registered; valid only when gnt_vld=1.
REQ-009 gnt  output  N  one-hot grant, decoded from gnt_idx with enable gnt_vld; all zero when gnt_vld=0.
REQ-010 expire  output  1  one-cycle pulse when a grant is force-released by the HOLD limit, registered.

Function
REQ-011 The block SHALL have two states: IDLE (gnt_vld=0) and GRANT (gnt_vld=1).
REQ-012 In IDLE, if req≠0, the block SHALL enter GRANT on the next edge, with gnt_idx = the first set req bit found by searching upward from ptr+1 modulo N; otherwise it stays in IDLE.
REQ-013 Latency: req asserted in cycle t while in IDLE gives gnt_vld=1 in cycle t+1.
REQ-014 Pointer ptr (WIDTH bits) SHALL be loaded with the new gnt_idx on every grant issue; its search wraps from N-1 to 0.
REQ-015 In GRANT, gnt_idx SHALL stay constant until release, whatever req does; a dropped req does not release the grant.
REQ-016 Release event = done=1, or hold_cnt = HOLD-1 with HOLD≠0 and done=0 (forced release).
REQ-017 On a release, the block SHALL re-arbitrate in the same cycle using the current req and the search from gnt_idx+1. If any req bit is set, it issues the new grant back-to-back (gnt_vld stays 1). Otherwise it goes to IDLE.
REQ-018 The releasing requester SHALL be granted again only if no other req bit is set (it has the lowest priority in the search).
REQ-019 hold_cnt SHALL clear on every grant issue and increment each GRANT cycle without release; its width is 8 bits.
REQ-020 expire SHALL be 1 in the cycle after a forced release and 0 otherwise; a done in the limit cycle counts as a normal release, with no expire.
REQ-021 done=1 in IDLE SHALL have no effect.

Reset
REQ-022 rst=1 at a clock edge SHALL set state=IDLE, gnt_vld=0, gnt=0, gnt_idx=0, expire=0, hold_cnt=0 and ptr=N-1, so the first grant searches from index 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant in the next cycle without an expire pulse; the first cycle after reset release behaves as IDLE.

Structure
REQ-024 Package LDL_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the 8-bit hold counter width constant.
REQ-025 The one-hot output SHALL come from one instance of the existing LDL_bin2hot (WIDTH=WIDTH, en=gnt_vld, x=gnt_idx, y=gnt); there are no other sub-modules.
REQ-026 The round-robin search SHALL be combinational, with a single registered stage for gnt_idx, gnt_vld and expire; there are no latches.

Verification (WIDTH=2, HOLD=4)
REQ-027 After reset, req=4'b0101 -> next cycle gnt_vld=1, gnt_idx=0, gnt=4'b0001.
REQ-028 req held at 4'b1111, done pulsed every grant cycle -> gnt_idx sequence 0,1,2,3,0 with gnt_vld continuously 1.
REQ-029 Single requester req=4'b0100, done never asserted -> grant for 4 cycles, then expire=1 for one cycle and re-grant to idx 2 back-to-back.
REQ-030 Owner idx 1 with req=4'b0011 and done=1 -> next grant idx 0 (wrap); with req=4'b0010 only -> idx 1 again.
REQ-031 rst=1 during GRANT idx 3 -> next cycle gnt=0, expire=0; then req=4'b1000 -> grant idx 3 one cycle after req.
REQ-032 done=1 in IDLE with req=0 -> outputs stay 0; in every cycle, check that gnt equals the decode of gnt_idx when gnt_vld=1 and is all zero otherwise.

Source files
------------

// File: rtl/ldl_arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package ldl_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/ldl_bin2hot.sv
// Binary-to-one-hot decoder with enable; output is all zero when disabled.
module ldl_bin2hot #(
  parameter int WIDTH = 2
) (
  input  logic                    en,
  input  logic [WIDTH-1:0]        x,
  output logic [(1<<WIDTH)-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[x] = 1'b1;
  end

endmodule

// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter with a registered grant index, optional hold limit and expire pulse.
// dbg_state exposes the FSM state.
module ldl_rr_arbiter
  import ldl_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int HOLD  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<WIDTH)-1:0] req,
  input  logic                  done,
  output logic                  gnt_vld,
  output logic [WIDTH-1:0]      gnt_idx,
  output logic [(1<<WIDTH)-1:0] gnt,
  output logic                  expire,
  output arb_state_e            dbg_state
);

  localparam int N = 1 << WIDTH;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD == 0) ? 0 : HOLD - 1);

  arb_state_e        state_q, state_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [WIDTH-1:0]  gnt_idx_q, gnt_idx_d;
  logic [WIDTH-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              expire_q, expire_d;

  logic [WIDTH-1:0]  base;
  logic [WIDTH:0]    pick;
  logic              release_ev;
  logic              forced;

  // First set bit searching upward from base+1; base itself is checked last.
  function automatic logic [WIDTH:0] rr_pick(input logic [N-1:0] r, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   res;
    logic [WIDTH-1:0] cand;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      cand = b + WIDTH'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    base       = (state_q == GRANT) ? gnt_idx_q : ptr_q;
    pick       = rr_pick(req, base);
    release_ev = 1'b0;
    forced     = 1'b0;
    state_d    = state_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    expire_d   = 1'b0;

    if (state_q == GRANT) begin
      forced     = !done && (HOLD != 0) && (hold_q == HOLD_LAST);
      release_ev = done || forced;
    end

    if (state_q == IDLE || release_ev) begin
      if (pick[WIDTH]) begin
        state_d   = GRANT;
        gnt_vld_d = 1'b1;
        gnt_idx_d = pick[WIDTH-1:0];
        ptr_d     = pick[WIDTH-1:0];
        hold_d    = '0;
      end else begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
        hold_d    = '0;
      end
      expire_d = forced;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= WIDTH'(N - 1);
      hold_q    <= '0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      expire_q  <= expire_d;
    end
  end

  assign gnt_vld   = gnt_vld_q;
  assign gnt_idx   = gnt_idx_q;
  assign expire    = expire_q;
  assign dbg_state = state_q;

  ldl_bin2hot #(.WIDTH(WIDTH)) u_bin2hot (
    .en (gnt_vld_q),
    .x  (gnt_idx_q),
    .y  (gnt)
  );

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Directed table-driven bench for the round-robin arbiter (WIDTH=2, HOLD=4).
module tb_ldl_rr_arbiter;
  import ldl_arb_pkg::*;

  localparam int WIDTH = 2;
  localparam int N     = 4;
  localparam int W     = 1 + 1 + WIDTH + N;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_idx;
  logic [N-1:0]     gnt;
  logic             expire;
  arb_state_e       dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic             rst;
    logic [N-1:0]     req;
    logic             done;
    logic             vld;
    logic [WIDTH-1:0] idx;
    logic             exp;
  } vec_t;

  vec_t vecs[$];

  ldl_rr_arbiter #(.WIDTH(WIDTH), .HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .expire    (expire),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [N-1:0] rq, input logic d,
                     input logic v, input logic [WIDTH-1:0] i, input logic e);
    vec_t t;
    t.rst = r; t.req = rq; t.done = d; t.vld = v; t.idx = i; t.exp = e;
    vecs.push_back(t);
  endtask

  function automatic logic [W-1:0] pack_exp(input logic v, input logic e, input logic [WIDTH-1:0] i);
    logic [N-1:0] oh;
    oh = v ? (N'(1) << i) : '0;
    return {v, e, i, oh};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req_v, $time);
    end
  endtask

  // driver: apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
    rst = r; req = rq; done = d;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop the expected record and compare every output
  task automatic score(input string tag);
    logic [W-1:0]     e;
    logic [N-1:0]     dec;
    e = exp_q.pop_front();
    chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(e[W-1]));
    chk({tag, ".expire"},  32'(expire),  32'(e[W-2]));
    chk({tag, ".gnt"},     32'(gnt),     32'(e[N-1:0]));
    if (e[W-1]) chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(e[WIDTH+N-1:N]));
    dec = gnt_vld ? (N'(1) << gnt_idx) : '0;
    chk({tag, ".decode"}, 32'(gnt), 32'(dec));
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1; req = '0; done = 1'b0;

    //  rst req     done  vld idx exp
    add(1, 4'b0000, 0,    0,  0,  0);  // reset state
    add(0, 4'b0101, 0,    1,  0,  0);  // first grant from index 0
    add(0, 4'b1111, 1,    1,  1,  0);  // rotation under full load
    add(0, 4'b1111, 1,    1,  2,  0);
    add(0, 4'b1111, 1,    1,  3,  0);
    add(0, 4'b1111, 1,    1,  0,  0);  // wrap 3 -> 0
    add(0, 4'b1111, 1,    1,  1,  0);
    add(0, 4'b0011, 1,    1,  0,  0);  // owner 1 releases, wrap to 0
    add(0, 4'b0010, 1,    1,  1,  0);
    add(0, 4'b0010, 1,    1,  1,  0);  // sole requester re-granted
    add(0, 4'b0000, 1,    0,  0,  0);  // release to idle
    add(0, 4'b0000, 1,    0,  0,  0);  // done in idle ignored
    add(0, 4'b0000, 1,    0,  0,  0);
    add(0, 4'b0100, 0,    1,  2,  0);  // hold limit: 4 grant cycles
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 0,    1,  2,  1);  // forced release, back-to-back
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 0,    1,  2,  0);
    add(0, 4'b0100, 1,    1,  2,  0);  // done in limit cycle: no expire
    add(0, 4'b1000, 1,    1,  3,  0);
    add(1, 4'b1000, 0,    0,  0,  0);  // reset mid-grant
    add(0, 4'b0000, 0,    0,  0,  0);
    add(0, 4'b1000, 0,    1,  3,  0);
    add(0, 4'b0000, 1,    0,  0,  0);
    add(0, 4'b0010, 0,    1,  1,  0);  // dropped req keeps grant
    add(0, 4'b0000, 0,    1,  1,  0);
    add(0, 4'b0000, 0,    1,  1,  0);
    add(0, 4'b0000, 0,    1,  1,  0);
    add(0, 4'b0000, 0,    0,  0,  1);  // forced release into idle
    add(0, 4'b0000, 0,    0,  0,  0);

    foreach (vecs[k]) begin
      exp_q.push_back(pack_exp(vecs[k].vld, vecs[k].exp, vecs[k].idx));
      step(vecs[k].rst, vecs[k].req, vecs[k].done);
      score($sformatf("vec%0d", k));
    end

    // bounded wait: single requester 0 must see expire on the 5th cycle
    step(0, 4'b0001, 0);
    exp_q.push_back(pack_exp(1'b1, 1'b0, 2'd0));
    score("hold.first");
    cyc  = 1;
    seen = 0;
    while (cyc < 20 && !seen) begin
      step(0, 4'b0001, 0);
      cyc++;
      if (expire) seen = 1;
    end
    chk("hold.expire_seen", 32'(seen), 32'd1);
    chk("hold.expire_cycle", 32'(cyc), 32'd5);
    exp_q.push_back(pack_exp(1'b1, 1'b1, 2'd0));
    score("hold.regrant");
    step(0, 4'b0000, 1);
    exp_q.push_back(pack_exp(1'b0, 1'b0, 2'd0));
    score("hold.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
